// File: rtl/wfi_ctrl_pkg.sv
// Shared WFI/interrupt-take definitions: FSM state encoding and irq_id cause codes
// (also consumed by the CSR unit).
package wfi_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SLEEP = 2'd1,
    WAKE  = 2'd2
  } wfi_state_t;

  localparam logic IRQ_ID_EXT = 1'b1;
  localparam logic IRQ_ID_TMR = 1'b0;

  localparam int unsigned WDT_W = 16;

endpackage

// File: rtl/stall_wdt.sv
// Stall watchdog: saturating count of consecutive stalled cycles with a sticky
// timeout flag once the count reaches LIMIT.
module stall_wdt
  import wfi_ctrl_pkg::*;
#(
  parameter logic [WDT_W-1:0] LIMIT = 16'd1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stall_i,
  output logic timeout_o
);

  localparam logic [WDT_W-1:0] CntMax = '1;

  logic [WDT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q;

  always_comb begin
    cnt_d = '0;
    if (stall_i) begin
      cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + WDT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_q | (cnt_d == LIMIT);
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/wfi_stall_ctrl.sv
// Pipeline stall / WFI sleep controller with one-shot interrupt-take strobe.
// Optional stall watchdog enabled by defining STALL_WDT_EN.
module wfi_stall_ctrl
  import wfi_ctrl_pkg::*;
#(
  parameter int unsigned STALL_LIMIT = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic im_wait,
  input  logic dm_wait,
  input  logic wfi_mem,
  input  logic mstatus_mie,
  input  logic mie_meie,
  input  logic mie_mtie,
  input  logic irq_ext,
  input  logic irq_tmr,
  output logic stall,
  output logic wfi,
  output logic interrupt_pulse,
  output logic irq_id,
  output logic timeout
);

  if (STALL_LIMIT < 1 || STALL_LIMIT > 65535) begin : g_bad_limit
    $error("wfi_stall_ctrl: STALL_LIMIT out of range 1..65535");
  end

  wfi_state_t state_q;
  logic       armed_q;
  logic       wfi_q;
  logic       ext_pend;
  logic       pend;
  logic       take;

  assign stall    = im_wait | dm_wait;
  assign ext_pend = irq_ext & mie_meie;
  assign pend     = ext_pend | (irq_tmr & mie_mtie);

  // Take is evaluated in the current cycle so a stalled request fires the first free cycle.
  assign take = rst_n & (state_q != SLEEP) & pend & mstatus_mie & armed_q & ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      armed_q <= 1'b1;
      wfi_q   <= 1'b0;
    end else begin
      armed_q <= ~pend | (armed_q & ~take);
      case (state_q)
        RUN: begin
          if (wfi_mem && !stall && !pend) begin
            state_q <= SLEEP;
            wfi_q   <= 1'b1;
          end
        end
        SLEEP: begin
          if (pend) begin
            state_q <= WAKE;
          end
        end
        WAKE: begin
          if (!stall) begin
            state_q <= RUN;
            wfi_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= RUN;
          wfi_q   <= 1'b0;
        end
      endcase
    end
  end

  assign wfi             = wfi_q;
  assign interrupt_pulse = take;
  assign irq_id          = (take && ext_pend) ? IRQ_ID_EXT : IRQ_ID_TMR;

`ifdef STALL_WDT_EN
  stall_wdt #(
    .LIMIT(WDT_W'(STALL_LIMIT))
  ) u_stall_wdt (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall_i  (stall),
    .timeout_o(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_wfi_stall_ctrl.sv
// Directed self-checking bench for wfi_stall_ctrl.
module tb_wfi_stall_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic im_wait, dm_wait, wfi_mem;
  logic mstatus_mie, mie_meie, mie_mtie;
  logic irq_ext, irq_tmr;
  logic stall, wfi, interrupt_pulse, irq_id, timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wfi_stall_ctrl #(.STALL_LIMIT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .im_wait        (im_wait),
    .dm_wait        (dm_wait),
    .wfi_mem        (wfi_mem),
    .mstatus_mie    (mstatus_mie),
    .mie_meie       (mie_meie),
    .mie_mtie       (mie_mtie),
    .irq_ext        (irq_ext),
    .irq_tmr        (irq_tmr),
    .stall          (stall),
    .wfi            (wfi),
    .interrupt_pulse(interrupt_pulse),
    .irq_id         (irq_id),
    .timeout        (timeout)
  );

  // Inputs change just after the rising edge; outputs are checked at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    im_wait = 0; dm_wait = 0; wfi_mem = 0;
    mstatus_mie = 0; mie_meie = 0; mie_mtie = 0;
    irq_ext = 0; irq_tmr = 0;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    im_wait = 1;
    mie_meie = 1; mstatus_mie = 1; irq_ext = 1;
    #3;
    checks++;
    if (wfi !== 1'b0 || interrupt_pulse !== 1'b0 || irq_id !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: wfi=%b pulse=%b irq_id=%b timeout=%b, want 0 0 0 0",
               wfi, interrupt_pulse, irq_id, timeout);
    end
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL reset_stall_follows: stall=%b want 1", stall);
    end
    idle_inputs();
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall_clear: stall=%b want 0", stall);
    end
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_sleep_wake();
    mie_mtie = 1; mstatus_mie = 1;
    wfi_mem = 1;
    @(negedge clk);
    checks++;
    if (wfi !== 1'b0) begin
      errors++;
      $display("FAIL sw_wfi_before: wfi=%b want 0", wfi);
    end
    tick();
    wfi_mem = 0;
    @(negedge clk);
    checks++;
    if (wfi !== 1'b1) begin
      errors++;
      $display("FAIL sw_sleep_entry: wfi=%b want 1", wfi);
    end
    for (int i = 0; i < 7; i++) tick();
    irq_tmr = 1;
    @(negedge clk);
    checks++;
    if (interrupt_pulse !== 1'b0 || wfi !== 1'b1) begin
      errors++;
      $display("FAIL sw_in_sleep: pulse=%b wfi=%b want 0 1", interrupt_pulse, wfi);
    end
    tick();
    @(negedge clk);
    checks++;
    if (interrupt_pulse !== 1'b1 || irq_id !== 1'b0 || wfi !== 1'b1) begin
      errors++;
      $display("FAIL sw_wake_pulse: pulse=%b irq_id=%b wfi=%b want 1 0 1",
               interrupt_pulse, irq_id, wfi);
    end
    tick();
    @(negedge clk);
    checks++;
    if (wfi !== 1'b0 || interrupt_pulse !== 1'b0) begin
      errors++;
      $display("FAIL sw_back_to_run: wfi=%b pulse=%b want 0 0", wfi, interrupt_pulse);
    end
    irq_tmr = 0;
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_deferred();
    int pulses;
    mie_meie = 1; mstatus_mie = 1;
    dm_wait = 1; irq_ext = 1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (interrupt_pulse === 1'b1) pulses++;
      tick();
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL def_no_pulse_in_stall: pulses=%0d want 0", pulses);
    end
    dm_wait = 0;
    @(negedge clk);
    checks++;
    if (interrupt_pulse !== 1'b1 || irq_id !== 1'b1) begin
      errors++;
      $display("FAIL def_pulse_after_stall: pulse=%b irq_id=%b want 1 1", interrupt_pulse, irq_id);
    end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      if (interrupt_pulse === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL def_single_pulse: extra pulses=%0d want 0", pulses);
    end
    checks++;
    if (irq_id !== 1'b0) begin
      errors++;
      $display("FAIL def_irq_id_idle: irq_id=%b want 0", irq_id);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_masked_wake();
    mie_meie = 1; mstatus_mie = 0;
    wfi_mem = 1;
    tick();
    wfi_mem = 0;
    tick();
    irq_ext = 1;
    @(negedge clk);
    checks++;
    if (wfi !== 1'b1 || interrupt_pulse !== 1'b0) begin
      errors++;
      $display("FAIL mw_sleep: wfi=%b pulse=%b want 1 0", wfi, interrupt_pulse);
    end
    tick();
    @(negedge clk);
    checks++;
    if (wfi !== 1'b1 || interrupt_pulse !== 1'b0) begin
      errors++;
      $display("FAIL mw_wake: wfi=%b pulse=%b want 1 0", wfi, interrupt_pulse);
    end
    tick();
    @(negedge clk);
    checks++;
    if (wfi !== 1'b0 || interrupt_pulse !== 1'b0) begin
      errors++;
      $display("FAIL mw_run: wfi=%b pulse=%b want 0 0", wfi, interrupt_pulse);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_simultaneous();
    mie_meie = 1; mie_mtie = 1; mstatus_mie = 1;
    wfi_mem = 1; irq_ext = 1; irq_tmr = 1;
    @(negedge clk);
    checks++;
    if (interrupt_pulse !== 1'b1 || irq_id !== 1'b1) begin
      errors++;
      $display("FAIL sim_pulse_ext_priority: pulse=%b irq_id=%b want 1 1", interrupt_pulse, irq_id);
    end
    tick();
    wfi_mem = 0;
    @(negedge clk);
    checks++;
    if (wfi !== 1'b0 || interrupt_pulse !== 1'b0) begin
      errors++;
      $display("FAIL sim_no_sleep: wfi=%b pulse=%b want 0 0", wfi, interrupt_pulse);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_in_sleep();
    mie_meie = 1; mstatus_mie = 1;
    wfi_mem = 1;
    tick();
    wfi_mem = 0;
    tick();
    checks++;
    if (wfi !== 1'b1) begin
      errors++;
      $display("FAIL rs_sleep_entry: wfi=%b want 1", wfi);
    end
    rst_n = 0;
    #1;
    checks++;
    if (wfi !== 1'b0 || interrupt_pulse !== 1'b0) begin
      errors++;
      $display("FAIL rs_async_clear: wfi=%b pulse=%b want 0 0", wfi, interrupt_pulse);
    end
    tick();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (wfi !== 1'b0 || interrupt_pulse !== 1'b0) begin
        errors++;
        $display("FAIL rs_after_release_%0d: wfi=%b pulse=%b want 0 0", i, wfi, interrupt_pulse);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_watchdog();
    logic exp_to;
`ifdef STALL_WDT_EN
    exp_to = 1'b1;
`else
    exp_to = 1'b0;
`endif
    do_reset();
    im_wait = 1;
    tick();
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL wdt_before_limit: timeout=%b want 0", timeout);
    end
    tick();
    im_wait = 0;
    @(negedge clk);
    checks++;
    if (timeout !== exp_to) begin
      errors++;
      $display("FAIL wdt_at_limit: timeout=%b want %b", timeout, exp_to);
    end
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (timeout !== exp_to) begin
      errors++;
      $display("FAIL wdt_sticky: timeout=%b want %b", timeout, exp_to);
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL wdt_reset_clear: timeout=%b want 0", timeout);
    end
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_sleep_wake();
    test_deferred();
    test_masked_wake();
    test_simultaneous();
    test_reset_in_sleep();
    test_watchdog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wfi_stall_ctrl.md
WFI_STALL_CTRL -- requirements
Module: wfi_stall_ctrl

Interface
REQ-001 SHALL have parameter STALL_LIMIT, default 1023, consecutive stalled cycles before timeout (range 1..65535).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port im_wait  input  1  instruction memory not ready.
REQ-005 SHALL have port dm_wait  input  1  data memory not ready.
REQ-006 SHALL have port wfi_mem  input  1  valid WFI instruction in MEM stage.
REQ-007 SHALL have ports mstatus_mie, mie_meie, mie_mtie  input  1 each  global, external and timer interrupt enables.
REQ-008 SHALL have ports irq_ext, irq_tmr  input  1 each  level-sensitive interrupt requests, synchronous to clk.
REQ-009 SHALL have port stall  output  1  hold for all pipeline registers.
REQ-010 SHALL have port wfi  output  1  sleep hold for the pipeline registers, overridden by interrupt_pulse.
REQ-011 SHALL have port interrupt_pulse  output  1  one-cycle interrupt-take strobe.
REQ-012 SHALL have port irq_id  output  1  cause of current pulse: 1 external, 0 timer.
REQ-013 SHALL have port timeout  output  1  sticky stall-watchdog flag.

Function
REQ-014 SHALL drive stall = im_wait | dm_wait combinationally, in every FSM state.
REQ-015 SHALL define pend = (irq_ext & mie_meie) | (irq_tmr & mie_mtie).
REQ-016 SHALL implement FSM states RUN, SLEEP, WAKE.
REQ-017 RUN -> SLEEP SHALL occur when wfi_mem & !stall & !pend; otherwise RUN holds, and WFI with pend already high retires as a NOP.
REQ-018 SLEEP -> WAKE SHALL occur when pend = 1, independent of mstatus_mie and of stall.
REQ-019 WAKE -> RUN SHALL occur when stall = 0; WAKE holds while stall = 1.
REQ-020 wfi SHALL be 1 in SLEEP and WAKE, 0 in RUN.
REQ-021 An armed flag SHALL be set at reset and whenever pend = 0, and cleared in the cycle interrupt_pulse = 1.
REQ-022 interrupt_pulse SHALL be 1 for exactly one cycle when pend & mstatus_mie & armed & !stall, in RUN or WAKE, never in SLEEP.
REQ-023 A pending interrupt blocked by stall SHALL be deferred, not dropped: the pulse fires in the first cycle stall = 0 with the condition still true.
REQ-024 In WAKE with mstatus_mie = 0, SHALL return to RUN with no pulse; execution resumes after the WFI.
REQ-025 irq_id SHALL be 1 if irq_ext & mie_meie, else 0 (external wins when both are pending); it is valid only while interrupt_pulse = 1 and is 0 otherwise.
REQ-026 If wfi_mem and pend rise in the same cycle, SHALL stay in RUN and pulse the same cycle when REQ-022 holds.

Reset
REQ-027 On rst_n low, SHALL immediately force state RUN, armed = 1, wfi = 0, interrupt_pulse = 0, irq_id = 0, timeout = 0, and clear the watchdog counter.
REQ-028 Reset asserted in SLEEP or WAKE SHALL abort the sleep with no pulse after release.
REQ-029 stall SHALL follow its inputs during reset.

Configuration
REQ-030 Macro STALL_WDT_EN compiled in: a 16-bit counter SHALL increment on each cycle stall = 1, clear on stall = 0, and saturate. timeout SHALL set when the count reaches STALL_LIMIT and stay set until reset.
REQ-031 Macro STALL_WDT_EN absent: no counter SHALL exist and timeout SHALL be tied 0.

Structure
REQ-032 The FSM state enum typedef (wfi_state_t) and the constants IRQ_ID_EXT = 1 and IRQ_ID_TMR = 0 SHALL live in shared package wfi_ctrl_pkg, consumed by the CSR unit.
REQ-033 The watchdog SHALL be sub-module stall_wdt, instantiated only under STALL_WDT_EN.

Verification
REQ-034 Sleep/wake: mie_mtie = 1, mstatus_mie = 1, wfi_mem pulse -> wfi = 1 next cycle; irq_tmr = 1 at cycle 10 -> WAKE at 11, interrupt_pulse = 1 and irq_id = 0 at 11, wfi = 0 at 12.
REQ-035 Deferred pulse: irq_ext = 1 with mie_meie = 1 and mstatus_mie = 1 while dm_wait = 1 for 5 cycles -> no pulse during the stall, one pulse in the first cycle dm_wait = 0, irq_id = 1, no second pulse while irq_ext stays high.
REQ-036 Masked wake: in SLEEP with mstatus_mie = 0, irq_ext = 1 -> WAKE then RUN, wfi = 0 with interrupt_pulse held 0.
REQ-037 Simultaneous and reset cases: wfi_mem and irq_ext rise together -> no SLEEP, pulse same cycle; rst_n low in SLEEP -> wfi = 0 immediately, no pulse after release.
REQ-038 Watchdog with STALL_WDT_EN and STALL_LIMIT = 4: im_wait = 1 for 4 cycles -> timeout = 1 and remains set after im_wait = 0; without the macro, timeout stays 0.
